// File: rtl/uart_rx_fifo_if.sv
// Receive-buffer interface: writer side from uart_receive, reader side from the
// APB register block; the FIFO connects through the slave modport.
interface uart_rx_fifo_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
);
   logic              fifo_en;
   logic              fifo_clr;
   logic [1:0]        trig_lvl;
   logic [3:0]        frame_len;
   logic              baud_tick;
   logic              wr_vld;
   logic [DATA_W-1:0] wr_data;
   logic              wr_pe;
   logic              wr_fe;
   logic              rd_en;
   logic              ovr_clr;
   logic [DATA_W-1:0] rd_data;
   logic              rd_pe;
   logic              rd_fe;
   logic              empty;
   logic              full;
   logic [ADDR_W:0]   level;
   logic              trig_hit;
   logic              timeout_int;
   logic              overrun;

   modport master (
      output fifo_en, fifo_clr, trig_lvl, frame_len, baud_tick,
             wr_vld, wr_data, wr_pe, wr_fe, rd_en, ovr_clr,
      input  rd_data, rd_pe, rd_fe, empty, full, level,
             trig_hit, timeout_int, overrun
   );

   modport slave (
      input  fifo_en, fifo_clr, trig_lvl, frame_len, baud_tick,
             wr_vld, wr_data, wr_pe, wr_fe, rd_en, ovr_clr,
      output rd_data, rd_pe, rd_fe, empty, full, level,
             trig_hit, timeout_int, overrun
   );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO with trigger levels, character timeout and sticky overrun.
// Optional UART_RX_FIFO_ERR_TAG_EN stores per-entry parity/framing flags.
module uart_rx_fifo #(
   parameter int DATA_W     = 8,
   parameter int ADDR_W     = 4,
   parameter int TOUT_CHARS = 4
) (
   input  logic           sys_clk,
   input  logic           rst,
   uart_rx_fifo_if.slave  bus
);
   localparam int DEPTH = 2 ** ADDR_W;
   localparam int CW    = ADDR_W + 8;
`ifdef UART_RX_FIFO_ERR_TAG_EN
   localparam int EW = DATA_W + 2;
`else
   localparam int EW = DATA_W;
`endif

   logic [EW-1:0]     mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [ADDR_W:0]   level_reg;
   logic [EW-1:0]     last_reg;
   logic              fifo_en_reg, en_chg_reg, overrun_reg;
   logic [CW-1:0]     tout_cnt_reg;

   logic              flush, is_empty, is_full, rd_acc, wr_acc, ovf, ovw;
   logic [EW-1:0]     wr_entry, head;
   logic [ADDR_W-1:0] wr_addr;
   logic [ADDR_W:0]   thr;
   logic [31:0]       tout_limit, tout_cnt_ext;

   // A fifo_en toggle is seen one cycle late and then behaves as a flush.
   assign flush    = bus.fifo_clr | en_chg_reg;
   assign is_empty = (level_reg == '0);
   assign is_full  = bus.fifo_en ? (level_reg == (ADDR_W+1)'(DEPTH))
                                 : (level_reg == (ADDR_W+1)'(1));
   assign rd_acc   = bus.rd_en & ~is_empty & ~flush;
   assign wr_acc   = bus.wr_vld & ~flush & (~is_full | bus.rd_en);
   assign ovf      = bus.wr_vld & ~flush & is_full & ~bus.rd_en;
   assign ovw      = ovf & ~bus.fifo_en;
   assign wr_addr  = wr_acc ? wr_ptr_reg : rd_ptr_reg;

`ifdef UART_RX_FIFO_ERR_TAG_EN
   assign wr_entry = {bus.wr_fe, bus.wr_pe, bus.wr_data};
`else
   assign wr_entry = bus.wr_data;
`endif

   always_ff @(posedge sys_clk) begin
      if (wr_acc | ovw)
         mem[wr_addr] <= wr_entry;
   end

   assign tout_limit   = 32'(TOUT_CHARS) * {28'd0, bus.frame_len} * 32'd16;
   assign tout_cnt_ext = 32'(tout_cnt_reg);

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         level_reg    <= '0;
         last_reg     <= '0;
         fifo_en_reg  <= bus.fifo_en;
         en_chg_reg   <= 1'b0;
         overrun_reg  <= 1'b0;
         tout_cnt_reg <= '0;
      end else begin
         fifo_en_reg <= bus.fifo_en;
         en_chg_reg  <= bus.fifo_en ^ fifo_en_reg;
         if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
         end else begin
            if (wr_acc)
               wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (rd_acc) begin
               rd_ptr_reg <= rd_ptr_reg + 1'b1;
               last_reg   <= mem[rd_ptr_reg];
            end
            case ({wr_acc, rd_acc})
               2'b10:   level_reg <= level_reg + 1'b1;
               2'b01:   level_reg <= level_reg - 1'b1;
               default: level_reg <= level_reg;
            endcase
         end
         if (ovf)
            overrun_reg <= 1'b1;
         else if (bus.ovr_clr)
            overrun_reg <= 1'b0;
         // Idle timer only runs while characters sit unread in FIFO mode.
         if (wr_acc | bus.rd_en | flush | is_empty | ~bus.fifo_en)
            tout_cnt_reg <= '0;
         else if (bus.baud_tick && tout_cnt_ext < tout_limit)
            tout_cnt_reg <= tout_cnt_reg + 1'b1;
      end
   end

   // Once drained, the last character read stays visible.
   assign head = is_empty ? last_reg : mem[rd_ptr_reg];
   assign bus.rd_data = head[DATA_W-1:0];

`ifdef UART_RX_FIFO_ERR_TAG_EN
   assign bus.rd_pe = head[DATA_W];
   assign bus.rd_fe = head[DATA_W+1];
`else
   logic pe_sticky_reg, fe_sticky_reg;
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         pe_sticky_reg <= 1'b0;
         fe_sticky_reg <= 1'b0;
      end else begin
         if ((wr_acc | ovw) & bus.wr_pe)
            pe_sticky_reg <= 1'b1;
         else if (bus.ovr_clr)
            pe_sticky_reg <= 1'b0;
         if ((wr_acc | ovw) & bus.wr_fe)
            fe_sticky_reg <= 1'b1;
         else if (bus.ovr_clr)
            fe_sticky_reg <= 1'b0;
      end
   end
   assign bus.rd_pe = pe_sticky_reg;
   assign bus.rd_fe = fe_sticky_reg;
`endif

   always_comb begin
      thr = (ADDR_W+1)'(1);
      case (bus.trig_lvl)
         2'd0:    thr = (ADDR_W+1)'(1);
         2'd1:    thr = (ADDR_W+1)'(DEPTH / 4);
         2'd2:    thr = (ADDR_W+1)'(DEPTH / 2);
         default: thr = (ADDR_W+1)'(DEPTH - 2);
      endcase
   end

   assign bus.empty       = is_empty;
   assign bus.full        = is_full;
   assign bus.level       = level_reg;
   assign bus.trig_hit    = bus.fifo_en & (level_reg >= thr);
   assign bus.timeout_int = (tout_cnt_ext >= tout_limit);
   assign bus.overrun     = overrun_reg;
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised receive buffer for the next-generation UART. It replaces the single-entry receive buffer register with a DEPTH-entry FIFO between the receiver (uart_receive) and the APB register block.
- Adds programmable trigger levels, a character-timeout interrupt, a sticky overrun flag and a 16550-style non-FIFO (depth-1) mode.
- All logic runs on sys_clk; bit timing comes from the existing 16x receive clock-enable.

Parameters:
DATA_W, 8, character width in bits (5..9).
ADDR_W, 4, pointer width; DEPTH = 2**ADDR_W entries (ADDR_W >= 2).
TOUT_CHARS, 4, character times of idle before the timeout interrupt.

Ports:
sys_clk  in  1  system clock
rst  in  1  synchronous reset, active-high
fifo_en  in  1  1 = FIFO mode; 0 = single holding register
fifo_clr  in  1  one-cycle pulse: flush contents
trig_lvl  in  2  trigger select: 0 -> 1, 1 -> DEPTH/4, 2 -> DEPTH/2, 3 -> DEPTH-2
frame_len  in  4  bits per frame, start to stop inclusive (7..13)
baud_tick  in  1  16x-baud enable (receive_clk_en)
wr_vld  in  1  one-cycle pulse: character received
wr_data  in  DATA_W  received character
wr_pe  in  1  parity error for wr_data
wr_fe  in  1  framing error for wr_data
rd_en  in  1  one-cycle pulse: host reads RBR
ovr_clr  in  1  one-cycle pulse: host reads LSR; clears overrun
rd_data  out  DATA_W  head entry (first-word fall-through)
rd_pe  out  1  head parity error
rd_fe  out  1  head framing error
empty  out  1  no entries
full  out  1  level equals effective depth
level  out  ADDR_W+1  entry count
trig_hit  out  1  trigger level reached
timeout_int  out  1  character timeout pending
overrun  out  1  sticky overrun

Behaviour:
Reset (rst=1 at a clock edge):
- Pointers, level, timeout counter and overrun clear.
- Outputs: rd_data=0, rd_pe=0, rd_fe=0, empty=1, full=0, level=0, trig_hit=0, timeout_int=0, overrun=0.
- Reset mid-frame discards all contents.

Effective depth:
- DEPTH when fifo_en=1, otherwise 1.
- Any change of fifo_en, sampled against a registered copy, acts as fifo_clr in the next cycle.

Flush (fifo_clr or fifo_en change):
- Empties the FIFO and clears the timeout logic next cycle.
- Overrun is not cleared.
- A wr_vld in the same cycle as a flush is discarded.

Write:
- wr_vld with not full: store {wr_fe, wr_pe, wr_data} at the write pointer, increment the pointer (wraps modulo DEPTH), level+1.
- wr_vld when full with fifo_en=1: character dropped, overrun=1 next cycle.
- wr_vld when full with fifo_en=0: the entry is overwritten, overrun=1.

Read:
- rd_en with not empty: increment the read pointer, level-1.
- rd_en when empty: no state change; rd_data/rd_pe/rd_fe keep their last value.
- Outputs reflect the head entry combinationally from storage; read latency 0 cycles.

Simultaneous events:
- wr_vld and rd_en together when full: both accepted, level unchanged, no overrun.
- wr_vld and rd_en together when empty: write accepted, read ignored.
- Otherwise both take effect and level is unchanged.

Flags:
- empty = (level==0); full = (level==effective depth).
- trig_hit = fifo_en & (level >= selected threshold), combinational from registered level.
- trig_hit is 0 when fifo_en=0; the register block uses ~empty instead.

Overrun:
- Sticky until ovr_clr.
- ovr_clr and a new overrun in the same cycle leave overrun=1.

Timeout counter:
- Width ADDR_W+8 bits.
- Limit = TOUT_CHARS * frame_len * 16, computed at full width with no truncation.
- Cleared on accepted write, on rd_en, on flush, or whenever empty or fifo_en=0.
- Otherwise increments on each baud_tick and saturates at the limit.
- timeout_int=1 while the counter equals the limit; it drops the cycle after the next read, write or flush.
- A frame_len change mid-count takes effect immediately; if count >= the new limit, timeout_int asserts.

Optional Feature:
UART_RX_FIFO_ERR_TAG_EN:
- Defined: each entry stores wr_pe/wr_fe alongside the data (DATA_W+2 bits); rd_pe/rd_fe report the head entry's flags.
- Undefined: storage is DATA_W bits. rd_pe/rd_fe are sticky flags, set by any accepted write carrying the error, cleared by ovr_clr or reset.

Test Plan:
- Reset, fifo_en=1, ADDR_W=4: write 0x41..0x50 (16 chars) -> full=1, level=16. 17th write 0x51 -> dropped, overrun=1. Read 16 -> data 0x41..0x50 in order, empty=1.
- fifo_en=0: write 0x11 then 0x22 with no read -> rd_data=0x22, overrun=1. ovr_clr -> overrun=0.
- trig_lvl=2: after 7 writes trig_hit=0, after the 8th trig_hit=1. trig_lvl=3 -> trig_hit=0 until level=14.
- frame_len=10, one char stored, no activity -> timeout_int=1 after exactly 640 baud_ticks. A read clears it the next cycle. With an empty FIFO no timeout occurs.
- Full FIFO with wr_vld and rd_en in the same cycle -> level stays 16, overrun=0, new char appears last. Empty FIFO with both -> level=1.
- Write with wr_pe=1 (ERR_TAG_EN defined) -> rd_pe=1 only while that entry is at the head. fifo_en 1->0 with 5 entries -> empty=1 two cycles later.
